// File: rtl/gpio_input_capture.sv
// GPIO input conditioner: two-flop synchroniser and per-bit debounce.
// Debounced changes are timestamped and queued for a valid/ready consumer.
module gpio_input_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int TS_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              gpio_in,
    output logic [WIDTH-1:0]              stable_value,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [WIDTH-1:0]              evt_value,
    output logic [WIDTH-1:0]              evt_changed,
    output logic [TS_WIDTH-1:0]           evt_ts,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   QCNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   QCNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    logic [WIDTH-1:0]    sync1_q, sync1_d;
    logic [WIDTH-1:0]    sync2_q, sync2_d;
    logic [WIDTH-1:0]    stable_q, stable_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                overflow_q, overflow_d;

    logic [WIDTH-1:0]    val_mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]    chg_mem_q [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] ts_mem_q  [FIFO_DEPTH];

    logic push, pop, full, accept, drop;

    // Each bit keeps its own run-length counter of cycles spent disagreeing with stable.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stable_bit_d;

            always_comb begin
                cnt_d        = cnt_q;
                stable_bit_d = stable_q[gi];
                if (sync2_q[gi] == stable_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    stable_bit_d = sync2_q[gi];
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = stable_bit_d;
        end
    endgenerate

    always_comb begin
        sync1_d = gpio_in;
        sync2_d = sync1_q;
        ts_d    = ts_q + TS_ONE;

        push   = (stable_d != stable_q);
        pop    = (count_q != '0) && evt_ready;
        full   = (count_q == QCNT_MAX);
        // A pop on a full queue frees the slot the simultaneous push needs.
        accept = push && (!full || pop);
        drop   = push && full && !pop;

        wr_ptr_d = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + QCNT_ONE;
        end else if (!accept && pop) begin
            count_d = count_q - QCNT_ONE;
        end

        overflow_d = drop | (overflow_q & ~clear_overflow);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                val_mem_q[i] <= '0;
                chg_mem_q[i] <= '0;
                ts_mem_q[i]  <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (accept) begin
                val_mem_q[wr_ptr_q] <= stable_d;
                chg_mem_q[wr_ptr_q] <= stable_d ^ stable_q;
                ts_mem_q[wr_ptr_q]  <= ts_q;
            end
        end
    end

    assign stable_value = stable_q;
    assign evt_valid    = (count_q != '0);
    assign evt_value    = val_mem_q[rd_ptr_q];
    assign evt_changed  = chg_mem_q[rd_ptr_q];
    assign evt_ts       = ts_mem_q[rd_ptr_q];
    assign evt_count    = count_q;
    assign overflow     = overflow_q;

endmodule
